// File: rtl/mem_refill_arbiter_pkg.sv
// Shared types for the L1 refill arbiter: FSM states, grant IDs, return-beat record.
// Round-robin selection is enabled by defining MEM_REFILL_ARBITER_RR_EN.
package mem_refill_arbiter_pkg;

    localparam int unsigned P_BURST_DEFAULT = 8;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } grant_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
        logic [23:0] flags;
    } ret_beat_t;

    function automatic grant_t other_side(input grant_t g);
        return (g == GNT_INST) ? GNT_DATA : GNT_INST;
    endfunction

endpackage

// File: rtl/mem_refill_arbiter_select.sv
// Two-way winner picker for the refill arbiter.
// MEM_REFILL_ARBITER_RR_EN: round-robin via last_grant; otherwise fixed instruction priority.
module mem_refill_arbiter_select
    import mem_refill_arbiter_pkg::*;
(
`ifdef MEM_REFILL_ARBITER_RR_EN
    input  logic   iCLOCK,
    input  logic   inRESET,
    input  logic   update_i,
`endif
    input  logic   inst_req_i,
    input  logic   data_req_i,
    output grant_t winner_o
);

`ifdef MEM_REFILL_ARBITER_RR_EN
    grant_t last_grant_q;
    grant_t last_grant_d;

    // Reset to the data side so the instruction side wins the first tie.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            last_grant_q <= GNT_DATA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        winner_o = GNT_INST;
        if (inst_req_i && data_req_i) begin
            winner_o = other_side(last_grant_q);
        end else if (data_req_i) begin
            winner_o = GNT_DATA;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (update_i) begin
            last_grant_d = winner_o;
        end
    end
`else
    always_comb begin
        winner_o = GNT_INST;
        if (!inst_req_i && data_req_i) begin
            winner_o = GNT_DATA;
        end
    end
`endif

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares one burst memory port between the L1 I-cache and D-cache refill paths.
// Optional round-robin arbitration: define MEM_REFILL_ARBITER_RR_EN.
module mem_refill_arbiter
    import mem_refill_arbiter_pkg::*;
#(
    parameter int unsigned P_BURST = P_BURST_DEFAULT
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iREMOVE,
    input  logic        iINST_REQ,
    output logic        oINST_LOCK,
    input  logic [1:0]  iINST_MMUMOD,
    input  logic [31:0] iINST_ADDR,
    output logic        oINST_VALID,
    output logic [63:0] oINST_DATA,
    output logic [23:0] oINST_MMU_FLAGS,
    input  logic        iDATA_REQ,
    output logic        oDATA_LOCK,
    input  logic [1:0]  iDATA_MMUMOD,
    input  logic [31:0] iDATA_ADDR,
    output logic        oDATA_VALID,
    output logic [63:0] oDATA_DATA,
    output logic [23:0] oDATA_MMU_FLAGS,
    output logic        oMEM_REQ,
    input  logic        iMEM_LOCK,
    output logic [1:0]  oMEM_MMUMOD,
    output logic [31:0] oMEM_ADDR,
    input  logic        iMEM_VALID,
    input  logic [63:0] iMEM_DATA,
    input  logic [23:0] iMEM_MMU_FLAGS,
    output logic        oERR
);

    localparam logic [CNT_W-1:0] BURST_LAST = P_BURST[CNT_W-1:0];

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
    grant_t           grant_q, grant_d;
    logic             err_q, err_d;
    ret_beat_t        inst_ret_q, inst_ret_d;
    ret_beat_t        data_ret_q, data_ret_d;

    grant_t           winner;
    logic             any_req;
    logic             idle_accept;
    logic             gnt_req;
    logic [31:0]      gnt_addr;
    logic [1:0]       gnt_mod;

    assign any_req     = iINST_REQ | iDATA_REQ;
    assign idle_accept = (state_q == IDLE) && !iREMOVE && any_req && !iMEM_LOCK;
    assign gnt_req     = (grant_q == GNT_INST) ? iINST_REQ    : iDATA_REQ;
    assign gnt_addr    = (grant_q == GNT_INST) ? iINST_ADDR   : iDATA_ADDR;
    assign gnt_mod     = (grant_q == GNT_INST) ? iINST_MMUMOD : iDATA_MMUMOD;

    mem_refill_arbiter_select u_select (
`ifdef MEM_REFILL_ARBITER_RR_EN
        .iCLOCK     (iCLOCK),
        .inRESET    (inRESET),
        .update_i   (idle_accept),
`endif
        .inst_req_i (iINST_REQ),
        .data_req_i (iDATA_REQ),
        .winner_o   (winner)
    );

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            grant_q     <= GNT_INST;
            err_q       <= 1'b0;
            inst_ret_q  <= '0;
            data_ret_q  <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            grant_q     <= grant_d;
            err_q       <= err_d;
            inst_ret_q  <= inst_ret_d;
            data_ret_q  <= data_ret_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        issue_cnt_d      = issue_cnt_q;
        ret_cnt_d        = ret_cnt_q;
        grant_d          = grant_q;
        err_d            = err_q;
        inst_ret_d       = inst_ret_q;
        inst_ret_d.valid = 1'b0;
        data_ret_d       = data_ret_q;
        data_ret_d.valid = 1'b0;
        oINST_LOCK       = iMEM_LOCK;
        oDATA_LOCK       = iMEM_LOCK;
        oMEM_REQ         = 1'b0;
        oMEM_ADDR        = '0;
        oMEM_MMUMOD      = '0;

        // Returns are judged against beats issued in earlier cycles only.
        if (iMEM_VALID) begin
            if ((state_q == IDLE) || (ret_cnt_q >= issue_cnt_q)) begin
                err_d = 1'b1;
            end else begin
                ret_cnt_d = ret_cnt_q + 1'b1;
                if (state_q != DRAIN) begin
                    if (grant_q == GNT_INST) begin
                        inst_ret_d.valid = 1'b1;
                        inst_ret_d.data  = iMEM_DATA;
                        inst_ret_d.flags = iMEM_MMU_FLAGS;
                    end else begin
                        data_ret_d.valid = 1'b1;
                        data_ret_d.data  = iMEM_DATA;
                        data_ret_d.flags = iMEM_MMU_FLAGS;
                    end
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (iREMOVE) begin
                    oINST_LOCK = 1'b1;
                    oDATA_LOCK = 1'b1;
                end else if (any_req) begin
                    oMEM_REQ    = 1'b1;
                    oMEM_ADDR   = (winner == GNT_INST) ? iINST_ADDR   : iDATA_ADDR;
                    oMEM_MMUMOD = (winner == GNT_INST) ? iINST_MMUMOD : iDATA_MMUMOD;
                    oINST_LOCK  = (winner == GNT_INST) ? iMEM_LOCK : 1'b1;
                    oDATA_LOCK  = (winner == GNT_DATA) ? iMEM_LOCK : 1'b1;
                    if (idle_accept) begin
                        grant_d     = winner;
                        issue_cnt_d = 4'd1;
                        state_d     = (BURST_LAST == 4'd1) ? WAIT : ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (iREMOVE) begin
                    oINST_LOCK = 1'b1;
                    oDATA_LOCK = 1'b1;
                    state_d    = (ret_cnt_d == issue_cnt_q) ? IDLE : DRAIN;
                end else begin
                    oMEM_REQ    = gnt_req;
                    oMEM_ADDR   = gnt_addr;
                    oMEM_MMUMOD = gnt_mod;
                    oINST_LOCK  = (grant_q == GNT_INST) ? iMEM_LOCK : 1'b1;
                    oDATA_LOCK  = (grant_q == GNT_DATA) ? iMEM_LOCK : 1'b1;
                    if (gnt_req && !iMEM_LOCK) begin
                        issue_cnt_d = issue_cnt_q + 1'b1;
                        if (issue_cnt_d == BURST_LAST) begin
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                oINST_LOCK = 1'b1;
                oDATA_LOCK = 1'b1;
                if (iREMOVE) begin
                    state_d = (ret_cnt_d == issue_cnt_q) ? IDLE : DRAIN;
                end else if (ret_cnt_d == BURST_LAST) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                oINST_LOCK = 1'b1;
                oDATA_LOCK = 1'b1;
                if (ret_cnt_d == issue_cnt_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d == IDLE) && (state_q != IDLE)) begin
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
        end
    end

    assign oINST_VALID     = inst_ret_q.valid;
    assign oINST_DATA      = inst_ret_q.data;
    assign oINST_MMU_FLAGS = inst_ret_q.flags;
    assign oDATA_VALID     = data_ret_q.valid;
    assign oDATA_DATA      = data_ret_q.data;
    assign oDATA_MMU_FLAGS = data_ret_q.flags;
    assign oERR            = err_q;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Self-checking bench for mem_refill_arbiter: directed scenarios with random data,
// checked cycle by cycle against a burst-level reference model.
module tb_mem_refill_arbiter;

    localparam int P = 8;

    logic        iCLOCK = 1'b0;
    logic        inRESET;
    logic        iREMOVE;
    logic        iINST_REQ, oINST_LOCK, oINST_VALID;
    logic [1:0]  iINST_MMUMOD;
    logic [31:0] iINST_ADDR;
    logic [63:0] oINST_DATA;
    logic [23:0] oINST_MMU_FLAGS;
    logic        iDATA_REQ, oDATA_LOCK, oDATA_VALID;
    logic [1:0]  iDATA_MMUMOD;
    logic [31:0] iDATA_ADDR;
    logic [63:0] oDATA_DATA;
    logic [23:0] oDATA_MMU_FLAGS;
    logic        oMEM_REQ, iMEM_LOCK, iMEM_VALID, oERR;
    logic [1:0]  oMEM_MMUMOD;
    logic [31:0] oMEM_ADDR;
    logic [63:0] iMEM_DATA;
    logic [23:0] iMEM_MMU_FLAGS;

    mem_refill_arbiter #(.P_BURST(P)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iREMOVE(iREMOVE),
        .iINST_REQ(iINST_REQ), .oINST_LOCK(oINST_LOCK), .iINST_MMUMOD(iINST_MMUMOD),
        .iINST_ADDR(iINST_ADDR), .oINST_VALID(oINST_VALID), .oINST_DATA(oINST_DATA),
        .oINST_MMU_FLAGS(oINST_MMU_FLAGS),
        .iDATA_REQ(iDATA_REQ), .oDATA_LOCK(oDATA_LOCK), .iDATA_MMUMOD(iDATA_MMUMOD),
        .iDATA_ADDR(iDATA_ADDR), .oDATA_VALID(oDATA_VALID), .oDATA_DATA(oDATA_DATA),
        .oDATA_MMU_FLAGS(oDATA_MMU_FLAGS),
        .oMEM_REQ(oMEM_REQ), .iMEM_LOCK(iMEM_LOCK), .oMEM_MMUMOD(oMEM_MMUMOD),
        .oMEM_ADDR(oMEM_ADDR), .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA),
        .iMEM_MMU_FLAGS(iMEM_MMU_FLAGS), .oERR(oERR)
    );

    always #5 iCLOCK = ~iCLOCK;

    int checks = 0;
    int failures = 0;

    // Reference model: one burst record (owner, beats issued/returned, flushing).
    bit          m_busy, m_flush, m_err;
    int          m_owner, m_issued, m_returned, m_last;
    bit          e_val [2];
    logic [63:0] e_dat [2];
    logic [23:0] e_flg [2];

    // Stimulus state: requester backlogs, memory responder, lock/flush controls.
    int          i_left, d_left, mem_pend, lock_cycles, ret_pct;
    bit          rm, inj_mv;
    logic [31:0] i_addr, d_addr;
    logic [1:0]  i_mod, d_mod;
    int          obs_issue, obs_iv, obs_dv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input bit ir, input bit dr);
`ifdef MEM_REFILL_ARBITER_RR_EN
        if (ir && dr) return (m_last == 0) ? 1 : 0;
`endif
        return ir ? 0 : 1;
    endfunction

    task automatic cyc();
        bit ir, dr, ml, mv, acc, emreq;
        bit el [2];
        int who;
        logic [31:0] eaddr;
        logic [1:0]  emod;
        logic [63:0] md;
        logic [23:0] mf;
        ir = (i_left > 0);
        dr = (d_left > 0);
        ml = (lock_cycles > 0);
        mv = inj_mv || (mem_pend > 0 && $urandom_range(0, 99) < ret_pct);
        md = {$urandom, $urandom};
        mf = 24'($urandom);
        iINST_REQ = ir; iINST_ADDR = i_addr; iINST_MMUMOD = i_mod;
        iDATA_REQ = dr; iDATA_ADDR = d_addr; iDATA_MMUMOD = d_mod;
        iREMOVE = rm; iMEM_LOCK = ml; iMEM_VALID = mv;
        iMEM_DATA = md; iMEM_MMU_FLAGS = mf;

        el[0] = ml; el[1] = ml; emreq = 0; eaddr = '0; emod = '0; acc = 0; who = 0;
        if (!m_busy) begin
            if (rm) begin
                el[0] = 1; el[1] = 1;
            end else if (ir || dr) begin
                who = pick(ir, dr);
                el[who] = ml; el[1-who] = 1;
                emreq = 1; acc = !ml;
            end
        end else if (!m_flush && m_issued < P && !rm) begin
            who = m_owner;
            el[who] = ml; el[1-who] = 1;
            emreq = (who == 0) ? ir : dr;
            acc = emreq && !ml;
        end else begin
            el[0] = 1; el[1] = 1;
        end
        if (emreq) begin
            eaddr = (who == 0) ? i_addr : d_addr;
            emod  = (who == 0) ? i_mod  : d_mod;
        end

        #3;
        chk("inst_lock", oINST_LOCK, el[0]);
        chk("data_lock", oDATA_LOCK, el[1]);
        chk("mem_req", oMEM_REQ, emreq);
        if (emreq || !m_busy) begin
            chk("mem_addr", oMEM_ADDR, eaddr);
            chk("mem_mmumod", oMEM_MMUMOD, emod);
        end
        chk("inst_valid", oINST_VALID, e_val[0]);
        chk("data_valid", oDATA_VALID, e_val[1]);
        if (e_val[0]) begin
            chk("inst_data", oINST_DATA, e_dat[0]);
            chk("inst_flags", oINST_MMU_FLAGS, e_flg[0]);
        end
        if (e_val[1]) begin
            chk("data_data", oDATA_DATA, e_dat[1]);
            chk("data_flags", oDATA_MMU_FLAGS, e_flg[1]);
        end
        chk("err", oERR, m_err);
        if (oMEM_REQ === 1'b1 && !ml) obs_issue++;
        if (oINST_VALID === 1'b1) obs_iv++;
        if (oDATA_VALID === 1'b1) obs_dv++;

        e_val[0] = 0; e_val[1] = 0;
        if (mv) begin
            if (!m_busy || m_returned >= m_issued) begin
                m_err = 1;
            end else begin
                m_returned++;
                if (!m_flush) begin
                    e_val[m_owner] = 1; e_dat[m_owner] = md; e_flg[m_owner] = mf;
                end
            end
            if (mem_pend > 0) mem_pend--;
        end
        if (acc) begin
            if (!m_busy) begin
                m_busy = 1; m_owner = who; m_issued = 1; m_returned = 0; m_last = who;
            end else begin
                m_issued++;
            end
            mem_pend++;
            if (who == 0) begin
                i_left--; i_addr += 8; i_mod = 2'($urandom);
            end else begin
                d_left--; d_addr += 8; d_mod = 2'($urandom);
            end
        end
        if (m_busy && !m_flush && rm) m_flush = 1;
        if (m_busy && ((m_flush && m_returned == m_issued) || (m_issued == P && m_returned == P))) begin
            m_busy = 0; m_flush = 0;
        end
        if (lock_cycles > 0) lock_cycles--;
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        while ((m_busy || i_left > 0 || d_left > 0 || mem_pend > 0) && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, (n < budget), 1'b1);
        cyc();
    endtask

    task automatic issue_out(input string tag);
        int n = 0;
        while ((i_left > 0 || d_left > 0) && n < 60) begin
            cyc();
            n++;
        end
        chk(tag, (n < 60), 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_inst_valid"}, oINST_VALID, 1'b0);
        chk({tag, "_inst_data"}, oINST_DATA, 64'h0);
        chk({tag, "_inst_flags"}, oINST_MMU_FLAGS, 24'h0);
        chk({tag, "_data_valid"}, oDATA_VALID, 1'b0);
        chk({tag, "_data_data"}, oDATA_DATA, 64'h0);
        chk({tag, "_data_flags"}, oDATA_MMU_FLAGS, 24'h0);
        chk({tag, "_err"}, oERR, 1'b0);
        chk({tag, "_mem_req"}, oMEM_REQ, 1'b0);
        chk({tag, "_mem_addr"}, oMEM_ADDR, 32'h0);
        chk({tag, "_inst_lock"}, oINST_LOCK, 1'b0);
        chk({tag, "_data_lock"}, oDATA_LOCK, 1'b0);
    endtask

    task automatic model_reset();
        m_busy = 0; m_flush = 0; m_err = 0; m_owner = 0; m_issued = 0; m_returned = 0;
        m_last = 1; e_val[0] = 0; e_val[1] = 0;
        mem_pend = 0; lock_cycles = 0; rm = 0; inj_mv = 0; i_left = 0; d_left = 0;
    endtask

    initial begin
        model_reset();
        ret_pct = 0;
        i_addr = 32'h0; d_addr = 32'h0; i_mod = 2'd0; d_mod = 2'd0;
        inRESET = 1'b0; iREMOVE = 0; iINST_REQ = 0; iDATA_REQ = 0;
        iINST_ADDR = '0; iDATA_ADDR = '0; iINST_MMUMOD = '0; iDATA_MMUMOD = '0;
        iMEM_LOCK = 0; iMEM_VALID = 0; iMEM_DATA = '0; iMEM_MMU_FLAGS = '0;
        #12;
        chk_reset_outputs("reset");
        @(posedge iCLOCK);
        #1;
        inRESET = 1'b1;
        cyc();

        // Simultaneous requests out of reset; the instruction side has two lines queued.
        i_addr = $urandom & 32'hFFFF_FFC0; d_addr = $urandom & 32'hFFFF_FFC0;
        i_left = 2 * P; d_left = P; ret_pct = 60;
        run_until_idle("simul_timeout", 400);

        // Instruction-only refill at 0x1000, returns after all issues.
        obs_issue = 0; obs_iv = 0; obs_dv = 0;
        i_addr = 32'h1000; i_left = P; ret_pct = 0;
        issue_out("inst_issue_timeout");
        ret_pct = 100;
        run_until_idle("inst_ret_timeout", 100);
        chk("inst_issue_count", obs_issue, P);
        chk("inst_valid_count", obs_iv, P);
        chk("inst_data_valid_count", obs_dv, 0);

        // Memory lock held three cycles in the middle of a data burst.
        obs_issue = 0;
        d_addr = $urandom & 32'hFFFF_FFC0; d_left = P; ret_pct = 50;
        for (int n = 0; n < 40 && !(m_busy && m_issued >= 3); n++) cyc();
        lock_cycles = 3;
        run_until_idle("lock_timeout", 200);
        chk("lock_issue_count", obs_issue, P);

        // Flush after five issues and two returns.
        obs_issue = 0; obs_iv = 0; obs_dv = 0;
        i_addr = $urandom & 32'hFFFF_FFC0; i_left = 5; ret_pct = 0;
        issue_out("flush_issue_timeout");
        ret_pct = 100;
        for (int n = 0; n < 20 && m_returned < 2; n++) cyc();
        ret_pct = 0; rm = 1;
        cyc();
        rm = 0; ret_pct = 100;
        run_until_idle("drain_timeout", 100);
        chk("flush_issue_count", obs_issue, 5);
        chk("flush_inst_valid_count", obs_iv, 2);
        chk("flush_data_valid_count", obs_dv, 0);
        d_addr = $urandom & 32'hFFFF_FFC0; d_left = P; ret_pct = 70;
        run_until_idle("post_flush_timeout", 200);

        // Flush while idle, then a return with nothing outstanding.
        rm = 1;
        i_left = 1;
        cyc();
        rm = 0; i_left = 0;
        inj_mv = 1;
        cyc();
        inj_mv = 0;
        cyc();
        i_addr = $urandom & 32'hFFFF_FFC0; i_left = P; ret_pct = 80;
        run_until_idle("post_err_timeout", 200);

        // Asynchronous reset while waiting on returns.
        i_addr = $urandom & 32'hFFFF_FFC0; i_left = P; ret_pct = 0;
        issue_out("rst_issue_timeout");
        ret_pct = 100;
        cyc();
        cyc();
        iMEM_VALID = 0; iINST_REQ = 0; iDATA_REQ = 0; iMEM_LOCK = 0;
        #2;
        inRESET = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        @(posedge iCLOCK);
        #1;
        chk_reset_outputs("midrst_held");
        inRESET = 1'b1;
        i_addr = $urandom & 32'hFFFF_FFC0; d_addr = $urandom & 32'hFFFF_FFC0;
        i_left = P; d_left = P; ret_pct = 60;
        run_until_idle("post_rst_timeout", 400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_refill_arbiter.md
# mem_refill_arbiter

Two-requester arbiter that shares the single burst memory port between the L1 instruction cache refill path and the L1 data cache refill path. It sits between both L1 caches and the memory/MMU port. It grants one requester for a complete 8-beat line burst, with 64-bit beats. It forwards that requester's address beats to memory and steers the in-order return beats back to it. It drains cleanly when a flush is requested.

## Interface
- P_BURST, 8, beats per line refill, covering both request and return.
- iCLOCK  in  1  clock.
- inRESET  in  1  reset inRESET, asynchronous, active-low; clock iCLOCK.
- iREMOVE  in  1  flush; aborts the current burst and drains it.
- iINST_REQ  in  1  instruction-side address beat request.
- oINST_LOCK  out  1  instruction-side beat not accepted this cycle.
- iINST_MMUMOD  in  2  instruction-side MMU mode.
- iINST_ADDR  in  32  instruction-side beat address.
- oINST_VALID  out  1  return beat for the instruction side.
- oINST_DATA  out  64  return data for the instruction side.
- oINST_MMU_FLAGS  out  24  return flags for the instruction side.
- iDATA_REQ, oDATA_LOCK, iDATA_MMUMOD, iDATA_ADDR, oDATA_VALID, oDATA_DATA, oDATA_MMU_FLAGS: data-side copies of the instruction-side ports, with identical widths.
- oMEM_REQ  out  1  beat issued to memory.
- iMEM_LOCK  in  1  memory cannot accept a beat.
- oMEM_MMUMOD  out  2  MMU mode of the issued beat.
- oMEM_ADDR  out  32  address of the issued beat.
- iMEM_VALID  in  1  return beat valid.
- iMEM_DATA  in  64  return beat data.
- iMEM_MMU_FLAGS  in  24  return beat flags.
- oERR  out  1  sticky protocol error.

## Operation
- **Requester rules**
  - A requester holds REQ, ADDR and MMUMOD stable until the beat is accepted.
  - A beat is accepted when REQ && !LOCK.
  - REQ must not depend combinationally on LOCK.
- **States:** IDLE, ISSUE, WAIT, DRAIN.
- **Counters:** issue_cnt and ret_cnt, each 4 bits, range 0..P_BURST. Both clear on entry to IDLE.
- **IDLE**
  - The winner is chosen combinationally from the asserted REQs.
  - Winner's LOCK = iMEM_LOCK. Loser's LOCK = 1.
  - On acceptance: oMEM_REQ=1, grant register ← winner, issue_cnt=1, go to ISSUE.
  - With no REQ, both LOCKs = iMEM_LOCK and oMEM_* = 0.
- **ISSUE**
  - Only the granted side has LOCK = iMEM_LOCK; the other side has LOCK = 1.
  - oMEM_ADDR and oMEM_MMUMOD mux from the granted side.
  - Each accepted beat increments issue_cnt.
  - When issue_cnt reaches P_BURST, go to WAIT.
- **Return beats**
  - Every iMEM_VALID in ISSUE or WAIT increments ret_cnt.
  - The beat is registered to the granted side's VALID/DATA/FLAGS.
  - The non-granted side's VALID stays 0.
- **WAIT:** when ret_cnt reaches P_BURST (counting the beat arriving this cycle), go to IDLE.
- **iREMOVE in ISSUE or WAIT**
  - Go to DRAIN; no further beats are issued, and both LOCKs = 1.
  - In DRAIN, returns are counted but never delivered.
  - When ret_cnt == issue_cnt, go to IDLE.
  - If the count already matches in the iREMOVE cycle, go to IDLE directly.
- **iREMOVE in IDLE:** both LOCKs = 1 and no acceptance occurs.
- **Error:** iMEM_VALID in IDLE, or ret_cnt would exceed issue_cnt → the beat is dropped and oERR sets; it clears only on reset.
- **Same-cycle events:** an issue beat and a return beat in the same cycle are both counted.

## Timing
- **Reset:** state IDLE, counters 0, grant 0, all oX_VALID/DATA/FLAGS 0, oERR 0. oMEM_REQ = 0 while no REQ is asserted.
- **Request path:** combinational. A beat is issued in the same cycle it is accepted.
- **Return latency:** 1 cycle from iMEM_VALID to oX_VALID.
- **Back-to-back bursts:** the final return beat moves the arbiter to IDLE. The next burst's first beat can be accepted in the following cycle, which is the cycle the last data appears.
- **Minimum burst occupancy:** P_BURST issue cycles, plus the returns outstanding after the last issue.
- **Reset mid-burst:** everything returns to reset values immediately. Any stale returns in flight are the memory side's responsibility.

## Configuration
- `MEM_REFILL_ARBITER_RR_EN` defined:
  - Round-robin arbitration. A last_grant register updates on each ISSUE entry.
  - On a simultaneous REQ, the side that was not last granted wins.
  - last_grant resets to data, so the instruction side wins first.
- Undefined: fixed priority; the instruction side always wins a simultaneous REQ.

## Structure
- **Shared package mem_refill_arbiter_pkg:** state encoding (IDLE=0, ISSUE=1, WAIT=2, DRAIN=3), P_BURST default, and grant IDs (GNT_INST=0, GNT_DATA=1).
- **Sub-module:** mem_refill_arbiter_select, a 2-way winner picker holding last_grant. Under the macro-off build it reduces to fixed priority.

## Test plan
- **Instruction-only refill:** iINST_REQ alone with addresses 0x1000..0x1038 and no lock → 8 oMEM_REQ pulses with matching addresses. 8 returns with data k → oINST_VALID ×8 delayed 1 cycle; oDATA_VALID is never 1; state is IDLE after the 8th return.
- **Simultaneous REQ out of reset:**
  - Instruction granted first in both builds.
  - With RR_EN, the next simultaneous REQ grants data.
  - Without RR_EN, it grants instruction again.
- **iMEM_LOCK held 3 cycles mid-ISSUE:** the granted LOCK stays high for 3 cycles, issue_cnt freezes at its value, and the burst completes with exactly 8 issues.
- **iREMOVE after 5 issues and 2 returns:** DRAIN entered; 3 further returns are swallowed with no oX_VALID; IDLE follows; the next REQ is accepted.
- **Protocol error:** iMEM_VALID in IDLE → oERR=1 and stays high; no oX_VALID.
- **Reset mid-WAIT:** inRESET low asynchronously → all outputs 0 and IDLE within the reset.
